// File: rtl/pdm_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_decimator
//  Purpose  : PDM microphone front end. Generates the microphone clock,
//             samples the 1-bit stream, runs a 4th-order CIC decimator and
//             hands 16-bit signed PCM samples to the sender over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module pdm_decimator #(
    parameter int CLK_DIV    = 16,
    parameter int LOG2_DECIM = 6,
    parameter int OUT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pdm_clk,
    input  logic             pdm_data,
    output logic [OUT_W-1:0] sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int ACC_W  = 2 + 4 * LOG2_DECIM;
    localparam int SHIFT  = 4 * LOG2_DECIM + 1 - OUT_W;
    localparam int WARMUP = 4;

    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]        DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_C1   = 3'd1,
        ST_C2   = 3'd2,
        ST_C3   = 3'd3,
        ST_C4   = 3'd4,
        ST_EMIT = 3'd5
    } state_t;

    // Front end: divider, synchronizer, integrators, bit counter
    logic [DIV_W-1:0]        div_q, div_d;
    logic                    pdm_clk_q, pdm_clk_d;
    logic [1:0]              sync_q;
    logic signed [ACC_W-1:0] integ_q [4];
    logic signed [ACC_W-1:0] integ_d [4];
    logic [LOG2_DECIM-1:0]   bitcnt_q, bitcnt_d;
    logic                    dec_stb_q;

    // Comb section and output buffer
    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] dly_q [4];
    logic signed [ACC_W-1:0] dly_d [4];
    logic [2:0]              warm_q, warm_d;
    logic [OUT_W-1:0]        sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    logic                    w_wrap;
    logic                    w_dec;
    logic signed [ACC_W-1:0] w_bit;
    logic signed [ACC_W-1:0] w_shift;
    logic [OUT_W-1:0]        w_sat;

    // The bit is taken on the wrap edge, i.e. at the end of the low phase.
    assign w_wrap  = en && (div_q == DIV_LAST);
    assign w_dec   = w_wrap && (&bitcnt_q);
    assign w_bit   = sync_q[1] ? ACC_W'(1) : {ACC_W{1'b1}};
    assign w_shift = acc_q >>> SHIFT;

    // Next state of divider, integrator cascade and decimation counter
    always_comb begin
        div_d    = '0;
        bitcnt_d = bitcnt_q;
        integ_d  = integ_q;
        if (en && !w_wrap) begin
            div_d = div_q + DIV_W'(1);
        end
        // pdm_clk is registered against the next count so it is glitch free
        pdm_clk_d = en && (div_d < DIV_HALF);
        if (w_wrap) begin
            bitcnt_d   = bitcnt_q + LOG2_DECIM'(1);
            integ_d[0] = integ_q[0] + w_bit;
            for (int i = 1; i < 4; i++) begin
                integ_d[i] = integ_q[i] + integ_d[i-1];
            end
        end
    end

    // Front-end registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            pdm_clk_q <= 1'b0;
            sync_q    <= '0;
            bitcnt_q  <= '0;
            dec_stb_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                integ_q[i] <= '0;
            end
        end else begin
            div_q     <= div_d;
            pdm_clk_q <= pdm_clk_d;
            sync_q    <= {sync_q[0], pdm_data};
            bitcnt_q  <= bitcnt_d;
            dec_stb_q <= w_dec;
            integ_q   <= integ_d;
        end
    end

    // Scale the comb result to OUT_W and clamp to the representable range
    always_comb begin
        w_sat = w_shift[OUT_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_W-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_W-1:0];
        end
    end

    // Comb FSM: one comb stage per clock, then emit into the holding register
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        dly_d     = dly_q;
        warm_d    = warm_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (dec_stb_q) begin
                    acc_d   = integ_q[3];
                    state_d = ST_C1;
                end
            end
            ST_C1: begin
                acc_d    = acc_q - dly_q[0];
                dly_d[0] = acc_q;
                state_d  = ST_C2;
            end
            ST_C2: begin
                acc_d    = acc_q - dly_q[1];
                dly_d[1] = acc_q;
                state_d  = ST_C3;
            end
            ST_C3: begin
                acc_d    = acc_q - dly_q[2];
                dly_d[2] = acc_q;
                state_d  = ST_C4;
            end
            ST_C4: begin
                acc_d    = acc_q - dly_q[3];
                dly_d[3] = acc_q;
                state_d  = ST_EMIT;
            end
            ST_EMIT: begin
                state_d = ST_IDLE;
                // Early samples only prime the comb delays
                if (warm_q != 3'(WARMUP)) begin
                    warm_d = warm_q + 3'd1;
                end else if (!valid_q || sample_ready) begin
                    sample_d = w_sat;
                    valid_d  = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Comb and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            warm_q    <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            dly_q     <= dly_d;
            warm_q    <= warm_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign pdm_clk      = pdm_clk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pdm_decimator
//  Purpose  : Self-checking bench for pdm_decimator. Expected PCM values come
//             from a direct convolution of the captured bit stream with the
//             CIC impulse response (four cascaded length-64 boxcars).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pdm_decimator;

    localparam int R      = 64;
    localparam int HLEN   = 4 * (R - 1) + 1;
    localparam int M_ONE  = 0;
    localparam int M_ZERO = 1;
    localparam int M_ALT  = 2;
    localparam int M_RAND = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pdm_data = 1'b0;
    logic        sample_ready = 1'b0;
    logic        pdm_clk;
    logic [15:0] sample;
    logic        sample_valid;
    logic        overrun;

    int  h [HLEN];
    bit  bits [$];
    int  mode = M_ONE;
    bit  alt = 1'b0;
    int  n_pass = 0;
    int  n_fail = 0;
    int  n_checks = 0;

    always #5 clk = ~clk;

    pdm_decimator #(
        .CLK_DIV    (16),
        .LOG2_DECIM (6),
        .OUT_W      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .pdm_clk      (pdm_clk),
        .pdm_data     (pdm_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    // Microphone model: a new bit after each rising pdm_clk edge; the
    // decimator takes it at the next rising edge (end of the low phase).
    initial begin
        forever begin
            @(posedge pdm_clk);
            #1;
            case (mode)
                M_ONE:   pdm_data = 1'b1;
                M_ZERO:  pdm_data = 1'b0;
                M_ALT: begin
                    alt      = ~alt;
                    pdm_data = alt;
                end
                default: pdm_data = ($urandom_range(99) < 70);
            endcase
            bits.push_back(pdm_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Computed sample m (1-based) covers captured bits up to index 64*m.
    function automatic logic [15:0] model(input int m);
        longint y;
        longint s;
        int     k;
        y = 0;
        for (int j = 0; j < HLEN; j++) begin
            k = R * m - j;
            if (k >= 1 && k <= bits.size()) begin
                y += longint'(h[j]) * (bits[k-1] ? 64'sd1 : -64'sd1);
            end
        end
        s = y >>> 9;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (sample_valid !== 1'b1 && cyc < budget);
    endtask

    task automatic start_run(input int m);
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        bits.delete();
        mode = m;
        alt  = 1'b0;
        rst  = 1'b0;
        en   = 1'b1;
    endtask

    task automatic run_stream(input int m, input int nsamp, input string tag,
                              input bit has_const, input logic [15:0] cval);
        int cyc;
        sample_ready = 1'b1;
        start_run(m);
        for (int k = 1; k <= nsamp; k++) begin
            wait_valid((k == 1) ? 5200 : 1100, cyc);
            check({tag, "_seen"}, 32'(sample_valid), 32'd1);
            if (k == 1) check({tag, "_latency"}, 32'(cyc >= 5124 && cyc <= 5128), 32'd1);
            else        check({tag, "_period"}, 32'(cyc), 32'd1024);
            check({tag, "_model"}, 32'(sample), 32'(model(k + 4)));
            if (has_const) check({tag, "_value"}, 32'(sample), 32'(cval));
        end
    endtask

    initial begin
        int t [HLEN];
        int cyc, n_hi, n_lo, guard, cnt_clk, cnt_vld, changes;
        logic [15:0] held;

        // Impulse response of four cascaded boxcars of length R
        for (int i = 0; i < HLEN; i++) h[i] = (i < R) ? 1 : 0;
        repeat (3) begin
            for (int i = 0; i < HLEN; i++) begin
                t[i] = 0;
                for (int j = 0; j < R; j++) if (i - j >= 0) t[i] += h[i-j];
            end
            h = t;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pdm_clk", 32'(pdm_clk), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Divider period and duty
        rst = 1'b0;
        en  = 1'b1;
        repeat (40) @(negedge clk);
        guard = 0;
        while (pdm_clk !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
        while (pdm_clk !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        n_hi = 0;
        while (pdm_clk === 1'b1 && n_hi < 100) begin n_hi++; @(negedge clk); end
        n_lo = 0;
        while (pdm_clk === 1'b0 && n_lo < 100) begin n_lo++; @(negedge clk); end
        check("div_high", 32'(n_hi), 32'd8);
        check("div_low", 32'(n_lo), 32'd8);

        // Disable: clock stops low, nothing emitted
        en = 1'b0;
        @(negedge clk);
        check("en0_pdm_clk", 32'(pdm_clk), 32'd0);
        cnt_clk = 0;
        cnt_vld = 0;
        repeat (2000) begin
            @(negedge clk);
            if (pdm_clk !== 1'b0) cnt_clk++;
            if (sample_valid !== 1'b0) cnt_vld++;
        end
        check("en0_clk_idle", 32'(cnt_clk), 32'd0);
        check("en0_no_valid", 32'(cnt_vld), 32'd0);

        // Full-scale, zero-mean and random streams
        run_stream(M_ONE, 3, "pos", 1'b1, 16'h7FFF);
        run_stream(M_ZERO, 2, "neg", 1'b1, 16'h8000);
        run_stream(M_ALT, 2, "alt", 1'b1, 16'h0000);
        run_stream(M_RAND, 4, "rnd", 1'b0, 16'h0000);

        // Backpressure over three decimation periods
        sample_ready = 1'b0;
        start_run(M_RAND);
        wait_valid(5200, cyc);
        check("bp_seen", 32'(sample_valid), 32'd1);
        held = sample;
        check("bp_first", 32'(sample), 32'(model(5)));
        changes = 0;
        repeat (3 * 1024 + 50) begin
            @(negedge clk);
            if (sample !== held || sample_valid !== 1'b1) changes++;
        end
        check("bp_stable", 32'(changes), 32'd0);
        check("bp_overrun", 32'(overrun), 32'd1);
        sample_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", 32'(sample_valid), 32'd0);
        check("bp_held_kept", 32'(sample), 32'(held));
        wait_valid(1100, cyc);
        check("bp_fresh_seen", 32'(sample_valid), 32'd1);
        check("bp_fresh", 32'(sample), 32'(model(9)));

        // Reset while the next sample sits in comb stage 2
        repeat (1020) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rm_pdm_clk", 32'(pdm_clk), 32'd0);
        check("rm_sample", 32'(sample), 32'd0);
        check("rm_valid", 32'(sample_valid), 32'd0);
        check("rm_overrun", 32'(overrun), 32'd0);
        bits.delete();
        mode = M_ONE;
        @(negedge clk);
        rst = 1'b0;
        wait_valid(5200, cyc);
        check("rm_seen", 32'(sample_valid), 32'd1);
        check("rm_latency", 32'(cyc >= 5124 && cyc <= 5128), 32'd1);
        check("rm_value", 32'(sample), 32'h7FFF);

        // Transfer and EMIT on the same edge
        sample_ready = 1'b0;
        start_run(M_RAND);
        wait_valid(5200, cyc);
        check("sim_seen", 32'(sample_valid), 32'd1);
        check("sim_first", 32'(sample), 32'(model(5)));
        repeat (1023) @(negedge clk);
        check("sim_hold_valid", 32'(sample_valid), 32'd1);
        check("sim_hold_value", 32'(sample), 32'(model(5)));
        sample_ready = 1'b1;
        @(negedge clk);
        check("sim_valid_kept", 32'(sample_valid), 32'd1);
        check("sim_new_value", 32'(sample), 32'(model(6)));
        check("sim_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        check("sim_drained", 32'(sample_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
